mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_if.sv | 43 ++++
 rtl/mult_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_mult_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_arbiter_if.sv
// -----------------------------------------------------------------------------
// mult_arbiter_if
// Bundle between the two requesting channels, the shared 8x8 multiplier and the
// mult_arbiter block.
//   req0/req1, a0/b0/a1/b1 : channel requests and operands
//   gnt0/gnt1              : one-cycle grant pulses (operands captured)
//   res_vld0/res_vld1, res : result-valid pulses and 16-bit product
//   mult_start/_dataa/_datab, mult_done/_product : shared multiplier link
//   busy, err              : arbiter status and watchdog abort flag
// Modports: slave = the arbiter, master = the environment around it.
// -----------------------------------------------------------------------------
interface mult_arbiter_if;
    logic        req0;
    logic        req1;
    logic [7:0]  a0;
    logic [7:0]  b0;
    logic [7:0]  a1;
    logic [7:0]  b1;
    logic        gnt0;
    logic        gnt1;
    logic        res_vld0;
    logic        res_vld1;
    logic [15:0] res;
    logic        mult_start;
    logic [7:0]  mult_dataa;
    logic [7:0]  mult_datab;
    logic        mult_done;
    logic [15:0] mult_product;
    logic        busy;
    logic        err;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, mult_done, mult_product,
        output gnt0, gnt1, res_vld0, res_vld1, res,
               mult_start, mult_dataa, mult_datab, busy, err
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, mult_done, mult_product,
        input  gnt0, gnt1, res_vld0, res_vld1, res,
               mult_start, mult_dataa, mult_datab, busy, err
    );
endinterface

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Round-robin arbiter sharing one 8x8 multiplier between two channels.
// Flow: IDLE -> LAUNCH (grant + mult_start) -> DROP (wait for a stale done to
// clear) -> WAIT (wait for done, capture product) -> RESP (result pulse) -> IDLE.
// Ports:
//   clk     : rising-edge clock
//   reset_a : asynchronous active-high reset
//   bus     : mult_arbiter_if.slave (requests, grants, results, multiplier link)
// Parameter:
//   WDOG_LIMIT : cycle budget over DROP+WAIT, only used with the watchdog.
// Optional feature macro: MULT_ARB_WDOG_EN enables the 6-bit watchdog that
// aborts a stuck multiply with res=0 and err=1; without it err is tied low.
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int unsigned WDOG_LIMIT = 32'd63
) (
    input  logic          clk,
    input  logic          reset_a,
    mult_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_DROP   = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic        ch_r, ch_s;          // channel being served
    logic        last_r, last_s;      // channel served most recently
    logic        grant_ch_s;
    logic [7:0]  opa_r, opa_s;
    logic [7:0]  opb_r, opb_s;
    logic [15:0] res_r, res_s;
    logic        gnt0_r, gnt1_r, vld0_r, vld1_r, start_r, busy_r;

`ifdef MULT_ARB_WDOG_EN
    localparam logic [5:0] WDOG_LIMIT_C = 6'(WDOG_LIMIT);
    logic [5:0] wdog_r, wdog_s, wdog_inc_s;
    logic       abort_s;
    logic       err_r;
`endif

    // Round-robin pick: on a tie the channel not served last wins.
    always_comb begin
        grant_ch_s = 1'b0;
        if (bus.req0 && bus.req1) begin
            grant_ch_s = ~last_r;
        end else if (bus.req1) begin
            grant_ch_s = 1'b1;
        end else begin
            grant_ch_s = 1'b0;
        end
    end

    // Next-state, operand latch, result capture and watchdog decisions.
    always_comb begin
        state_s = state_r;
        ch_s    = ch_r;
        last_s  = last_r;
        opa_s   = opa_r;
        opb_s   = opb_r;
        res_s   = res_r;
`ifdef MULT_ARB_WDOG_EN
        wdog_s     = wdog_r;
        wdog_inc_s = wdog_r + 6'd1;
        abort_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_s = ST_LAUNCH;
                    ch_s    = grant_ch_s;
                    opa_s   = grant_ch_s ? bus.a1 : bus.a0;
                    opb_s   = grant_ch_s ? bus.b1 : bus.b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                state_s = ST_DROP;
`ifdef MULT_ARB_WDOG_EN
                wdog_s  = 6'd0;
`endif
            end
            ST_DROP: begin
                // A done still high here belongs to the previous operation.
                if (!bus.mult_done) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_DROP;
                end
`ifdef MULT_ARB_WDOG_EN
                wdog_s = wdog_inc_s;
                if (wdog_inc_s == WDOG_LIMIT_C) begin
                    state_s = ST_RESP;
                    res_s   = 16'd0;
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
`endif
            end
            ST_WAIT: begin
                if (bus.mult_done) begin
                    state_s = ST_RESP;
                    res_s   = bus.mult_product;
                end else begin
                    state_s = ST_WAIT;
                end
`ifdef MULT_ARB_WDOG_EN
                wdog_s = wdog_inc_s;
                // A real completion on the same edge takes priority.
                if (!bus.mult_done && (wdog_inc_s == WDOG_LIMIT_C)) begin
                    state_s = ST_RESP;
                    res_s   = 16'd0;
                    abort_s = 1'b1;
                end else begin
                    abort_s = 1'b0;
                end
`endif
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                last_s  = ch_r;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; outputs decode the next state so
    // they are flop-driven yet line up with the state they describe.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_r <= ST_IDLE;
            ch_r    <= 1'b0;
            last_r  <= 1'b1;
            opa_r   <= 8'd0;
            opb_r   <= 8'd0;
            res_r   <= 16'd0;
            gnt0_r  <= 1'b0;
            gnt1_r  <= 1'b0;
            vld0_r  <= 1'b0;
            vld1_r  <= 1'b0;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            ch_r    <= ch_s;
            last_r  <= last_s;
            opa_r   <= opa_s;
            opb_r   <= opb_s;
            res_r   <= res_s;
            gnt0_r  <= (state_s == ST_LAUNCH) && !ch_s;
            gnt1_r  <= (state_s == ST_LAUNCH) &&  ch_s;
            vld0_r  <= (state_s == ST_RESP)   && !ch_s;
            vld1_r  <= (state_s == ST_RESP)   &&  ch_s;
            start_r <= (state_s == ST_LAUNCH);
            busy_r  <= (state_s != ST_IDLE);
        end
    end

`ifdef MULT_ARB_WDOG_EN
    // Watchdog count and abort flag.
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            wdog_r <= 6'd0;
            err_r  <= 1'b0;
        end else begin
            wdog_r <= wdog_s;
            err_r  <= abort_s;
        end
    end

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.gnt0       = gnt0_r;
    assign bus.gnt1       = gnt1_r;
    assign bus.res_vld0   = vld0_r;
    assign bus.res_vld1   = vld1_r;
    assign bus.res        = res_r;
    assign bus.mult_start = start_r;
    assign bus.mult_dataa = opa_r;
    assign bus.mult_datab = opb_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
// Self-checking bench for mult_arbiter: directed vector table, hand-written
// corner sequences (tie-break, alternation, stale done, stuck multiplier,
// reset in flight) and two random requesters, all observed by a transaction
// level reference model (round-robin pointer plus expected product).
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    logic clk = 1'b0;
    logic reset_a;

    mult_arbiter_if bus ();

    mult_arbiter #(.WDOG_LIMIT(63)) dut (
        .clk     (clk),
        .reset_a (reset_a),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- multiplier model ----------------
    int          lat_cfg   = 3;
    int          stale_cfg = 0;
    bit          never_cfg = 1'b0;
    bit          rand_lat  = 1'b0;
    int          cnt, dcnt;
    bit          pend;
    logic [15:0] next_prod;

    always @(posedge clk or posedge reset_a) begin
        int l;
        if (reset_a) begin
            bus.mult_done    <= 1'b0;
            bus.mult_product <= 16'd0;
            pend <= 1'b0;
            cnt  <= 0;
            dcnt <= 0;
        end else if (bus.mult_start) begin
            l = rand_lat ? int'($urandom_range(1, 6)) : lat_cfg;
            next_prod <= bus.mult_dataa * bus.mult_datab;
            pend <= !never_cfg;
            cnt  <= stale_cfg + l;
            dcnt <= stale_cfg;
            if (stale_cfg == 0) bus.mult_done <= 1'b0;
        end else if (pend) begin
            if (dcnt == 1) bus.mult_done <= 1'b0;
            if (dcnt > 0) dcnt <= dcnt - 1;
            if (cnt == 1) begin
                bus.mult_done    <= 1'b1;
                bus.mult_product <= next_prod;
                pend <= 1'b0;
            end
            cnt <= cnt - 1;
        end
    end

    // ---------------- transaction-level reference model ----------------
    logic [1:0]  req_smp;
    bit          last_ch = 1'b1;
    bit          pend_m  = 1'b0;
    bit          pend_ch;
    logic [15:0] pend_prod;
    bit          expect_abort = 1'b0;
    bit          prev_vld = 1'b0;

    always @(posedge clk) req_smp = {bus.req1, bus.req0};

    always @(negedge clk) begin
        bit exp_ch;
        if (reset_a) begin
            pend_m = 1'b0; last_ch = 1'b1; prev_vld = 1'b0;
        end else begin
            if (bus.gnt0 || bus.gnt1) begin
                exp_ch = (req_smp == 2'b11) ? !last_ch : req_smp[1];
                check("gnt_onehot", {bus.gnt1, bus.gnt0} == 2'b11, 1'b0);
                check("gnt_had_req", req_smp != 2'b00, 1'b1);
                check("gnt_channel", bus.gnt1, exp_ch);
                check("gnt_while_busy", pend_m, 1'b0);
                check("gnt_idle_gap", prev_vld, 1'b0);
                check("gnt_with_start", bus.mult_start, 1'b1);
                pend_ch   = exp_ch;
                pend_prod = exp_ch ? bus.a1 * bus.b1 : bus.a0 * bus.b0;
                check("mult_dataa", bus.mult_dataa, exp_ch ? bus.a1 : bus.a0);
                check("mult_datab", bus.mult_datab, exp_ch ? bus.b1 : bus.b0);
                pend_m = 1'b1;
            end
            if (bus.res_vld0 || bus.res_vld1) begin
                check("vld_onehot", {bus.res_vld1, bus.res_vld0} == 2'b11, 1'b0);
                check("vld_expected", pend_m, 1'b1);
                check("vld_channel", bus.res_vld1, pend_ch);
                check("vld_err", bus.err, expect_abort);
                check("vld_res", bus.res, expect_abort ? 16'd0 : pend_prod);
                last_ch = pend_ch;
                pend_m  = 1'b0;
            end
            prev_vld = bus.res_vld0 || bus.res_vld1;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_gnt(output logic ch);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(bus.gnt0 || bus.gnt1) && n < 200);
        check("gnt_timeout", bus.gnt0 || bus.gnt1, 1'b1);
        ch = bus.gnt1;
    endtask

    task automatic wait_vld(output int n, output logic ch);
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.res_vld0 || bus.res_vld1) && n < 200);
        check("vld_timeout", bus.res_vld0 || bus.res_vld1, 1'b1);
        ch = bus.res_vld1;
    endtask

    task automatic requester(input logic ch, input int count);
        int n;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            @(negedge clk); #1;
            if (ch) begin
                bus.a1 = 8'($urandom); bus.b1 = 8'($urandom); bus.req1 = 1'b1;
            end else begin
                bus.a0 = 8'($urandom); bus.b0 = 8'($urandom); bus.req0 = 1'b1;
            end
            n = 0;
            do begin @(negedge clk); n++; end while (!(ch ? bus.gnt1 : bus.gnt0) && n < 300);
            check(ch ? "rand_gnt1_seen" : "rand_gnt0_seen", ch ? bus.gnt1 : bus.gnt0, 1'b1);
            #1;
            if (ch) bus.req1 = 1'b0; else bus.req0 = 1'b0;
        end
    endtask

    typedef struct {
        logic        r0, r1;
        logic [7:0]  a0, b0, a1, b1;
        int          lat, stale;
        logic        exp_ch;
        logic [15:0] exp_res;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic ch;
        int   n;
        bit   vld_seen;

        // pointer starts at ch1, so ties alternate 0,1,0,... from here
        vecs[0] = '{1'b1, 1'b0, 8'h0F, 8'h0F, 8'h00, 8'h00, 5, 0, 1'b0, 16'h00E1};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h12, 8'h34, 2, 0, 1'b1, 16'h03A8};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 8'hFF, 8'h12, 8'h34, 3, 0, 1'b0, 16'hFE01};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'hAB, 1, 0, 1'b1, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 8'h80, 8'h02, 8'h00, 8'h00, 2, 0, 1'b0, 16'h0100};
        vecs[5] = '{1'b1, 1'b0, 8'h07, 8'h06, 8'h00, 8'h00, 2, 3, 1'b0, 16'h002A}; // stale done
        vecs[6] = '{1'b1, 1'b1, 8'h10, 8'h10, 8'h20, 8'h20, 1, 0, 1'b1, 16'h0400};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'hFF, 8'hFF, 6, 0, 1'b1, 16'hFE01};

        reset_a = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = 8'd0; bus.b0 = 8'd0; bus.a1 = 8'd0; bus.b1 = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_gnt", {bus.gnt1, bus.gnt0}, 2'b00);
        check("rst_vld", {bus.res_vld1, bus.res_vld0}, 2'b00);
        check("rst_start", bus.mult_start, 1'b0);
        check("rst_res", bus.res, 16'd0);
        check("rst_data", {bus.mult_dataa, bus.mult_datab}, 16'd0);
        check("rst_err", bus.err, 1'b0);
        #1 reset_a = 1'b0;

        // ---- directed vector table ----
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            lat_cfg = vecs[i].lat; stale_cfg = vecs[i].stale;
            bus.a0 = vecs[i].a0; bus.b0 = vecs[i].b0;
            bus.a1 = vecs[i].a1; bus.b1 = vecs[i].b1;
            bus.req0 = vecs[i].r0; bus.req1 = vecs[i].r1;
            wait_gnt(ch);
            check("vec_gnt_ch", ch, vecs[i].exp_ch);
            #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
            wait_vld(n, ch);
            check("vec_vld_ch", ch, vecs[i].exp_ch);
            check("vec_res", bus.res, vecs[i].exp_res);
            check("vec_latency", n, vecs[i].stale + vecs[i].lat + 2);
        end
        stale_cfg = 0; lat_cfg = 3;

        // ---- simultaneous requests: ch0 first, then ch1 ----
        @(negedge clk); #1;
        bus.a0 = 8'hFF; bus.b0 = 8'hFF; bus.a1 = 8'h12; bus.b1 = 8'h34;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_gnt(ch); check("tie_first", ch, 1'b0);
        #1 bus.req0 = 1'b0;
        wait_vld(n, ch); check("tie_res0", bus.res, 16'hFE01);
        wait_gnt(ch); check("tie_second", ch, 1'b1);
        #1 bus.req1 = 1'b0;
        wait_vld(n, ch); check("tie_res1", bus.res, 16'h03A8);

        // ---- both held: grants alternate 0,1,0,1 ----
        @(negedge clk); #1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(ch);
            check("alt_grant", ch, i[0]);
        end
        #1 bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_vld(n, ch); check("alt_last_res", bus.res, 16'h03A8);

        // ---- multiplier never completes ----
        never_cfg = 1'b1;
        @(negedge clk); #1;
        bus.a0 = 8'h05; bus.b0 = 8'h05; bus.req0 = 1'b1;
        wait_gnt(ch); check("stuck_gnt", ch, 1'b0);
        #1 bus.req0 = 1'b0;
`ifdef MULT_ARB_WDOG_EN
        expect_abort = 1'b1;
        wait_vld(n, ch);
        check("wdog_latency", n, 64);
        check("wdog_err", bus.err, 1'b1);
        check("wdog_res", bus.res, 16'd0);
        #1 expect_abort = 1'b0;
        @(negedge clk); #1 bus.req0 = 1'b1;
        wait_gnt(ch);
        #1 bus.req0 = 1'b0;
        repeat (10) @(negedge clk);
`else
        vld_seen = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (bus.res_vld0 || bus.res_vld1) vld_seen = 1'b1;
        end
        check("stuck_no_vld", vld_seen, 1'b0);
        check("stuck_busy", bus.busy, 1'b1);
`endif

        // ---- asynchronous reset while waiting for the multiplier ----
        @(negedge clk); #3 reset_a = 1'b1;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_gnt_vld", {bus.gnt1, bus.gnt0, bus.res_vld1, bus.res_vld0}, 4'd0);
        check("arst_start_err", {bus.mult_start, bus.err}, 2'b00);
        check("arst_res", bus.res, 16'd0);
        check("arst_data", {bus.mult_dataa, bus.mult_datab}, 16'd0);
        repeat (2) @(negedge clk);
        #1 reset_a = 1'b0; never_cfg = 1'b0; lat_cfg = 3;
        vld_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_vld0 || bus.res_vld1) vld_seen = 1'b1;
        end
        check("post_rst_no_vld", vld_seen, 1'b0);
        check("post_rst_idle", bus.busy, 1'b0);

        // req1 first, req0 arriving while ch1 is in flight
        #1 bus.a1 = 8'h0B; bus.b1 = 8'h0D; bus.req1 = 1'b1;
        wait_gnt(ch); check("post_rst_first", ch, 1'b1);
        #1 bus.req1 = 1'b0; bus.a0 = 8'h02; bus.b0 = 8'h03; bus.req0 = 1'b1;
        wait_vld(n, ch); check("post_rst_res1", bus.res, 16'h008F);
        wait_gnt(ch); check("post_rst_second", ch, 1'b0);
        #1 bus.req0 = 1'b0;
        wait_vld(n, ch); check("post_rst_res0", bus.res, 16'h0006);

        // last served is ch0 now; a reset must restore ch0 priority on a tie
        @(negedge clk); #1 reset_a = 1'b1;
        @(negedge clk); #1 reset_a = 1'b0;
        bus.a0 = 8'h21; bus.b0 = 8'h03; bus.a1 = 8'h02; bus.b1 = 8'h02;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_gnt(ch); check("rst_ptr_tie", ch, 1'b0);
        #1 bus.req0 = 1'b0;
        wait_vld(n, ch); check("rst_ptr_res", bus.res, 16'h0063);
        wait_gnt(ch); check("rst_ptr_next", ch, 1'b1);
        #1 bus.req1 = 1'b0;
        wait_vld(n, ch); check("rst_ptr_res1", bus.res, 16'h0004);

        // ---- random traffic against the reference model ----
        rand_lat = 1'b1;
        fork
            requester(1'b0, 15);
            requester(1'b1, 15);
        join
        n = 0;
        while ((bus.busy || pend_m) && n < 100) begin @(negedge clk); n++; end
        check("drain_idle", bus.busy, 1'b0);
        check("drain_no_pending", pend_m, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
